// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the polarity of the datamemory WR_RD strobe.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } lsu_state_e;

  // Illegal size or a sub-word offset that is not naturally aligned.
  function automatic logic lsu_bad_size_align(input logic [1:0] size,
                                              input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Big-endian lane steering: extracts/extends the addressed byte or halfword
// of a memory word for loads, and splices store data into that lane.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane 0 is the most significant byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = word_i[8*(3-gi) +: 8];
    end
  endgenerate

  assign byte_sel = lane[offset_i];
  assign half_sel = offset_i[1] ? {lane[2], lane[3]} : {lane[0], lane[1]};

  always_comb begin
    load_o  = word_i;
    store_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o  = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
        store_o = word_i;
        store_o[{~offset_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_o  = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
        store_o = word_i;
        store_o[{~offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// CPU-side load/store unit driving a word-only datamemory; sub-word stores
// are done as read-modify-write because the memory has no byte enables.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [31:0]       mem_data_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_rd,
  input  logic [31:0]       mem_data_out
);

  // READ lasts MEM_RD_LAT+1 cycles; the 2-bit counter limits latency to 0..3.
  localparam logic [1:0] LAST_CNT = 2'(MEM_RD_LAT);

  lsu_state_e        state_q;
  logic              ready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [31:0]       resp_rdata_q;
  logic              wr_rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_in_q;
  logic [1:0]        cnt_q;

  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [1:0]        off_q;
  logic [31:0]       wdata_q;

  logic              req_err_d;
  logic [31:0]       load_d;
  logic [31:0]       merge_d;

  assign req_err_d = lsu_bad_size_align(req_size, req_addr[1:0])
                   || ((req_addr >> (ADDR_W + 2)) != 32'd0);

  lsu_byte_lane u_lane (
    .word_i     (mem_data_out),
    .offset_i   (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .load_o     (load_d),
    .store_o    (merge_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      wr_rd_q      <= MEM_READ;
      addr_q       <= '0;
      data_in_q    <= 32'd0;
      cnt_q        <= 2'd0;
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      off_q        <= 2'd0;
      wdata_q      <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            ready_q <= 1'b0;
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata;
            if (req_err_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'd0;
            end else begin
              addr_q <= req_addr[ADDR_W+1:2];
              cnt_q  <= 2'd0;
              if (req_we && req_size == SZ_WORD) begin
                state_q   <= WRITE;
                wr_rd_q   <= MEM_WRITE;
                data_in_q <= req_wdata;
              end else begin
                state_q <= READ;
              end
            end
          end
        end
        READ: begin
          // Memory word is sampled on the edge closing the final READ cycle.
          if (cnt_q == LAST_CNT) begin
            if (we_q) begin
              state_q   <= WRITE;
              wr_rd_q   <= MEM_WRITE;
              data_in_q <= merge_d;
            end else begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= load_d;
            end
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        WRITE: begin
          state_q      <= RESP;
          wr_rd_q      <= MEM_READ;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= 32'd0;
        end
        RESP: begin
          state_q      <= IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'd0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign mem_wr_rd   = wr_rd_q;
  assign mem_addr    = addr_q;
  assign mem_data_in = data_in_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a behavioural datamemory, a word-array
// reference model, and monitors for responses and memory writes.
module tb_load_store_unit;
  localparam int L  = 1;
  localparam int LI = (L == 0) ? 1 : L;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_data_in, mem_data_out;
  logic [9:0]  mem_addr;
  logic        mem_wr_rd;

  load_store_unit #(.ADDR_W(10), .MEM_RD_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_data_in(mem_data_in), .mem_addr(mem_addr),
    .mem_wr_rd(mem_wr_rd), .mem_data_out(mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 5) ? 32'h8899AABB : ((32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000);
  endfunction

  // Behavioural datamemory with MEM_RD_LAT read pipeline.
  logic        mem_init;
  logic [31:0] mem [0:1023];
  logic [31:0] pipe [1:3];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
    end else if (mem_wr_rd == 1'b0) begin
      mem[mem_addr] <= mem_data_in;
    end
    pipe[1] <= mem[mem_addr];
    pipe[2] <= pipe[1];
    pipe[3] <= pipe[2];
  end
  assign mem_data_out = (L == 0) ? mem[mem_addr] : pipe[LI];

  int cyc = 0;
  int n_acc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && req_valid && req_ready) n_acc <= n_acc + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_issued = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  typedef struct { logic [31:0] rdata; logic err; int due; } resp_t;
  typedef struct { logic [9:0] addr; logic [31:0] data; int due; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];
  logic [31:0] ref_mem [0:1023];

  // Reference model: big-endian lanes computed by shift and mask.
  function automatic logic m_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 0)
           || (a >= 32'd4096);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz,
                                          input logic uns, input logic [1:0] off);
    int sh;
    logic [31:0] v;
    if (sz == 2'b10) return w;
    if (sz == 2'b00) begin
      sh = (3 - int'(off)) * 8;
      v = (w >> sh) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFFFF00;
    end else begin
      sh = (2 - int'(off)) * 8;
      v = (w >> sh) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] off, input logic [31:0] wd);
    int sh;
    logic [31:0] m;
    if (sz == 2'b10) return wd;
    m  = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
    sh = (sz == 2'b00) ? (3 - int'(off)) * 8 : (2 - int'(off)) * 8;
    return (w & ~(m << sh)) | ((wd & m) << sh);
  endfunction

  // Response monitor and memory-write monitor.
  always @(negedge clk) begin
    resp_t r;
    wr_t   w;
    if (rst) begin
      if (resp_valid) begin
        chk("resp_expected", 32'(rq.size() > 0), 32'd1);
        if (rq.size() > 0) begin
          r = rq.pop_front();
          $display("resp cyc=%0d rdata=%h err=%0d", cyc, resp_rdata, resp_err);
          chk("resp_rdata", resp_rdata, r.rdata);
          chk("resp_err", 32'(resp_err), 32'(r.err));
          chk("resp_cycle", 32'(cyc), 32'(r.due));
        end
      end
      if (mem_wr_rd == 1'b0) begin
        chk("write_expected", 32'(wq.size() > 0), 32'd1);
        if (wq.size() > 0) begin
          w = wq.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(w.addr));
          chk("wr_data", mem_data_in, w.data);
          chk("wr_cycle", 32'(cyc), 32'(w.due));
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input logic [31:0] exp_wd, input logic track);
    bit    got;
    int    acc, k;
    resp_t r;
    wr_t   w;
    got = 0;
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      if (req_ready) begin
        @(posedge clk);
        #1;
        got = 1;
      end else begin
        @(negedge clk);
      end
    end
    chk("accept", 32'(got), 32'd1);
    if (got) begin
      n_issued++;
      acc = cyc;
      k = exp_err ? 1 : (!we ? 2 + L : ((sz == 2'b10) ? 2 : 3 + L));
      if (track) begin
        r.rdata = exp_rd; r.err = exp_err; r.due = acc + k - 1;
        rq.push_back(r);
        if (we && !exp_err) begin
          w.addr = addr[11:2]; w.data = exp_wd;
          w.due  = acc + ((sz == 2'b10) ? 0 : 1 + L);
          wq.push_back(w);
          ref_mem[addr[11:2]] = exp_wd;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic issue_m(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
    logic        err;
    logic [31:0] w, er;
    err = m_err(sz, addr);
    w   = ref_mem[addr[11:2]];
    er  = (err || we) ? 32'd0 : m_load(w, sz, uns, addr[1:0]);
    issue(we, sz, uns, addr, wd, er, err, m_merge(w, sz, addr[1:0], wd), 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (rq.size() > 0 || wq.size() > 0); i++) @(negedge clk);
    chk("drain_resp", 32'(rq.size()), 32'd0);
    chk("drain_wr", 32'(wq.size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [1:0] sz;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    mem_init = 1'b1;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_wr_rd", 32'(mem_wr_rd), 32'd1);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data_in", mem_data_in, 32'd0);
    mem_init = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // Directed lane, store and error cases.
    issue(0, 2'b00, 0, 32'h14, 0, 32'hFFFFFF88, 0, 0, 1);
    issue(0, 2'b00, 1, 32'h17, 0, 32'h000000BB, 0, 0, 1);
    issue(1, 2'b01, 0, 32'h16, 32'h00001234, 0, 0, 32'h88991234, 1);
    issue(0, 2'b10, 0, 32'h14, 0, 32'h88991234, 0, 0, 1);
    issue(1, 2'b10, 0, 32'h28, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 1);
    issue(0, 2'b10, 0, 32'h28, 0, 32'hDEADBEEF, 0, 0, 1);
    issue(0, 2'b01, 0, 32'h15, 0, 0, 1, 0, 1);
    issue(1, 2'b10, 0, 32'h2A, 32'h11111111, 0, 1, 0, 1);
    issue(0, 2'b10, 0, 32'h1000, 0, 0, 1, 0, 1);
    req_valid = 0;
    drain();

    // Reset during the WRITE cycle of a halfword store.
    issue(1, 2'b01, 0, 32'h14, 32'h0000CAFE, 0, 0, 0, 0);
    req_valid = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (mem_wr_rd == 1'b0) seen = 1;
    end
    chk("abort_write_seen", 32'(seen), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_wr_rd", 32'(mem_wr_rd), 32'd1);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 32'd1);
    issue(0, 2'b10, 0, 32'h14, 0, 32'h88991234, 0, 0, 1);
    req_valid = 0;
    drain();

    // Back-to-back word stores then loads with req_valid held high.
    for (int i = 0; i < 10; i++) issue(1, 2'b10, 0, 32'(i * 4), 32'(i), 0, 0, 32'(i), 1);
    for (int i = 0; i < 10; i++) issue(0, 2'b10, 0, 32'(i * 4), 0, 32'(i), 0, 0, 1);
    req_valid = 0;
    drain();

    // Randomized traffic checked against the reference model.
    for (int n = 0; n < 150; n++) begin
      sz = 2'($urandom_range(0, 3));
      issue_m(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63)),
              $urandom);
      if ($urandom_range(0, 1) == 0) begin
        req_valid = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    req_valid = 0;
    drain();

    chk("accept_count", 32'(n_acc), 32'(n_issued));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
